sm3_msg_feeder: RTL

- Initiator side of the SM3 core message interface.
- Buffers 32-bit message words written by the bus in a small FIFO.
- Streams a message of programmed byte length into the core's msg data / byte-enable / valid / last / ready handshake, generating the last-beat byte enables itself.
- Captures the core's 256-bit digest into a holding register and raises a sticky done flag for the CPU-side wrapper.

---
 rtl/sm3_msg_feeder_if.sv | 25 ++
 rtl/sm3_msg_feeder.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/sm3_msg_feeder_if.sv
// Message beat handshake between the feeder and the SM3 core.
// The feeder drives data/enables/valid/last; the core answers with ready.
interface sm3_msg_feeder_if;
  logic [31:0] msg_otpt_d_o;
  logic [3:0]  msg_otpt_vld_byte_o;
  logic        msg_otpt_vld_o;
  logic        msg_otpt_lst_o;
  logic        msg_otpt_rdy_i;

  modport master (
    output msg_otpt_d_o,
    output msg_otpt_vld_byte_o,
    output msg_otpt_vld_o,
    output msg_otpt_lst_o,
    input  msg_otpt_rdy_i
  );

  modport slave (
    input  msg_otpt_d_o,
    input  msg_otpt_vld_byte_o,
    input  msg_otpt_vld_o,
    input  msg_otpt_lst_o,
    output msg_otpt_rdy_i
  );
endinterface

// File: rtl/sm3_msg_feeder.sv
// SM3 message feeder: word FIFO, length-driven beat streaming with
// last-beat byte enables, and a sticky digest holding register.
module sm3_msg_feeder #(
  parameter int FIFO_DEPTH = 8,
  parameter int LEN_W      = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start_i,
  input  logic [LEN_W-1:0]            msg_len_i,
  input  logic                        wr_en_i,
  input  logic [31:0]                 wr_data_i,
  output logic                        fifo_full_o,
  output logic [$clog2(FIFO_DEPTH):0] fifo_cnt_o,
  sm3_msg_feeder_if.master            m,
  input  logic [255:0]                res_inpt_i,
  input  logic                        res_inpt_vld_i,
  output logic [255:0]                res_o,
  output logic                        busy_o,
  output logic                        done_o,
  output logic                        err_o
);

  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int WL_W = LEN_W - 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_WAIT
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [31:0]     r_mem [FIFO_DEPTH];
  logic [AW-1:0]   r_wp;
  logic [AW-1:0]   r_rp;
  logic [AW:0]     r_cnt;
  logic            w_full;
  logic            w_empty;
  logic            w_push;
  logic            w_pop;
  logic            w_ovf;

  logic [WL_W-1:0] r_words_left;
  logic [1:0]      r_tail;
  logic [LEN_W:0]  w_len_p3;
  logic [WL_W-1:0] w_words_init;

  logic            w_vld;
  logic            w_lst;
  logic            w_load;
  logic            w_zero_err;
  logic            w_capture;
  logic [3:0]      w_tail_be;
  logic [3:0]      w_be;

  logic [255:0]    r_res;
  logic            r_done;
  logic            r_err;

  assign w_full  = (r_cnt == (AW+1)'(FIFO_DEPTH));
  assign w_empty = (r_cnt == '0);
  assign w_push  = wr_en_i & ~w_full;
  // A push into a full FIFO is lost even if a pop frees a slot this cycle.
  assign w_ovf   = wr_en_i & w_full;
  assign w_pop   = w_vld & m.msg_otpt_rdy_i;

  assign w_len_p3     = {1'b0, msg_len_i} + (LEN_W+1)'(3);
  assign w_words_init = w_len_p3[LEN_W:2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_mem[r_wp] <= wr_data_i;
        r_wp        <= r_wp + AW'(1);
      end
      if (w_pop) begin
        r_rp <= r_rp + AW'(1);
      end
      if (w_push && !w_pop) begin
        r_cnt <= r_cnt + (AW+1)'(1);
      end else if (!w_push && w_pop) begin
        r_cnt <= r_cnt - (AW+1)'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_vld       = 1'b0;
    w_lst       = 1'b0;
    w_load      = 1'b0;
    w_zero_err  = 1'b0;
    w_capture   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start_i) begin
          if (msg_len_i != '0) begin
            w_load      = 1'b1;
            w_state_nxt = S_SEND;
          end else begin
            w_zero_err = 1'b1;
          end
        end
      end
      S_SEND: begin
        w_vld = ~w_empty;
        w_lst = w_vld & (r_words_left == WL_W'(1));
        if (w_lst && m.msg_otpt_rdy_i) begin
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (res_inpt_vld_i) begin
          w_capture   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_comb begin
    w_tail_be = 4'b1111;
    unique case (r_tail)
      2'd1:    w_tail_be = 4'b1000;
      2'd2:    w_tail_be = 4'b1100;
      2'd3:    w_tail_be = 4'b1110;
      default: w_tail_be = 4'b1111;
    endcase
  end

  assign w_be = !w_vld ? 4'b0000 :
                w_lst  ? w_tail_be : 4'b1111;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_words_left <= '0;
      r_tail       <= '0;
    end else if (w_load) begin
      r_words_left <= w_words_init;
      r_tail       <= msg_len_i[1:0];
    end else if (w_pop) begin
      r_words_left <= r_words_left - WL_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_res  <= '0;
      r_done <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      if (w_capture) begin
        r_res <= res_inpt_i;
      end
      if (w_load) begin
        r_done <= 1'b0;
      end else if (w_capture) begin
        r_done <= 1'b1;
      end
      if (w_ovf || w_zero_err) begin
        r_err <= 1'b1;
      end else if (w_load) begin
        r_err <= 1'b0;
      end
    end
  end

  assign m.msg_otpt_d_o        = w_vld ? r_mem[r_rp] : 32'h0;
  assign m.msg_otpt_vld_byte_o = w_be;
  assign m.msg_otpt_vld_o      = w_vld;
  assign m.msg_otpt_lst_o      = w_lst;

  assign fifo_full_o = w_full;
  assign fifo_cnt_o  = r_cnt;
  assign res_o       = r_res;
  assign busy_o      = (r_state != S_IDLE);
  assign done_o      = r_done;
  assign err_o       = r_err;

endmodule
